// File: rtl/gpmc_async_bridge.sv
// gpmc_async_bridge: oversampling GPMC (muxed AD, async single/burst) to
// valid/ack host request bridge, single clock domain.
// Optional macro GPMC_WAIT_EN: drive gpmc_wait while a host request is in
// flight; when undefined gpmc_wait is tied low.
module gpmc_async_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           gpmc_ad_in,
    output logic [15:0]           gpmc_ad_out,
    output logic                  gpmc_ad_oe,
    input  logic                  gpmc_advn,
    input  logic                  gpmc_csn,
    input  logic                  gpmc_wein,
    input  logic                  gpmc_oen,
    output logic                  gpmc_wait,
    output logic                  host_req,
    output logic                  host_we,
    output logic [ADDR_WIDTH-1:0] host_addr,
    output logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_ack,
    input  logic [DATA_WIDTH-1:0] host_rdata
);

    typedef enum logic [2:0] {IDLE, ADDR, WR_REQ, RD_REQ, HOLD} state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0]       csn_q, advn_q, wein_q, oen_q;
    logic [SYNC_STAGES-1:0][15:0] ad_q;
    logic                         csn_s, advn_s, wein_s, oen_s;
    logic [15:0]                  ad_s;
    logic                         wein_p, oen_p;
    logic                         wr_fall, rd_fall;
    logic                         wr_op;
    logic                         addr_ld, addr_inc, go_wr, go_rd, rd_done;
    logic [15:0]                  rdata_ext;

    // Pad enable follows the raw pins so turnaround tracks the CPU directly
    assign gpmc_ad_oe = ~gpmc_csn & gpmc_advn & ~gpmc_oen & gpmc_wein & ~rst;

    // Synchronisers: control idles high, AD idles low
    always_ff @(posedge clk) begin
        if (rst) begin
            csn_q  <= '1;
            advn_q <= '1;
            wein_q <= '1;
            oen_q  <= '1;
            ad_q   <= '0;
            wein_p <= 1'b1;
            oen_p  <= 1'b1;
        end else begin
            csn_q  <= {csn_q[SYNC_STAGES-2:0], gpmc_csn};
            advn_q <= {advn_q[SYNC_STAGES-2:0], gpmc_advn};
            wein_q <= {wein_q[SYNC_STAGES-2:0], gpmc_wein};
            oen_q  <= {oen_q[SYNC_STAGES-2:0], gpmc_oen};
            ad_q   <= {ad_q[SYNC_STAGES-2:0], gpmc_ad_in};
            wein_p <= wein_s;
            oen_p  <= oen_s;
        end
    end

    assign csn_s   = csn_q[SYNC_STAGES-1];
    assign advn_s  = advn_q[SYNC_STAGES-1];
    assign wein_s  = wein_q[SYNC_STAGES-1];
    assign oen_s   = oen_q[SYNC_STAGES-1];
    assign ad_s    = ad_q[SYNC_STAGES-1];
    assign wr_fall = wein_p & ~wein_s;
    assign rd_fall = oen_p & ~oen_s;

    assign host_req = (state == WR_REQ) || (state == RD_REQ);
    assign host_we  = (state == WR_REQ);

    // Zero-extend read data onto the 16-bit pad bus
    always_comb begin
        rdata_ext = '0;
        rdata_ext[DATA_WIDTH-1:0] = host_rdata;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d  = state;
        addr_ld  = 1'b0;
        addr_inc = 1'b0;
        go_wr    = 1'b0;
        go_rd    = 1'b0;
        rd_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!csn_s && !advn_s) begin
                    addr_ld = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (csn_s) begin
                    state_d = IDLE;
                end else if (!advn_s) begin
                    addr_ld = 1'b1;
                end else if (wr_fall && rd_fall) begin
                    // both strobes at once is a protocol error: ignore it
                    state_d = ADDR;
                end else if (wr_fall) begin
                    go_wr   = 1'b1;
                    state_d = WR_REQ;
                end else if (rd_fall) begin
                    go_rd   = 1'b1;
                    state_d = RD_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                // a pending request always completes, even if csn lifts
                if (host_ack) begin
                    rd_done = (state == RD_REQ);
                    state_d = csn_s ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (csn_s) begin
                    state_d = IDLE;
                end else if (wr_op ? wein_s : oen_s) begin
                    addr_inc = 1'b1;
                    state_d  = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and request/response datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            host_addr   <= '0;
            host_wdata  <= '0;
            gpmc_ad_out <= '0;
            wr_op       <= 1'b0;
        end else begin
            state <= state_d;
            if (addr_ld)  host_addr <= ad_s[ADDR_WIDTH-1:0];
            if (addr_inc) host_addr <= host_addr + ADDR_WIDTH'(1);
            if (go_wr) begin
                host_wdata <= ad_s[DATA_WIDTH-1:0];
                wr_op      <= 1'b1;
            end
            if (go_rd)   wr_op       <= 1'b0;
            if (rd_done) gpmc_ad_out <= rdata_ext;
        end
    end

`ifdef GPMC_WAIT_EN
    logic wait_q;

    // Wait spans the request and the cycle after its ack
    always_ff @(posedge clk) begin
        if (rst) wait_q <= 1'b0;
        else     wait_q <= (state_d == WR_REQ) || (state_d == RD_REQ) ||
                           (host_req && host_ack);
    end

    assign gpmc_wait = wait_q;
`else
    assign gpmc_wait = 1'b0;
`endif

endmodule

// File: tb/tb_gpmc_async_bridge.sv
// tb_gpmc_async_bridge: directed tests for gpmc_async_bridge (16-bit and
// 8-bit instances sharing the GPMC pins).
module tb_gpmc_async_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ad_in = '0;
    logic        advn = 1'b1, csn = 1'b1, wein = 1'b1, oen = 1'b1;
    logic [15:0] ad_out;
    logic        ad_oe, gwait;
    logic        req, we, ack = 1'b0;
    logic [15:0] addr, wdata, rdata = '0;

    logic [15:0] n_ad_out;
    logic        n_ad_oe, n_wait, n_req, n_we, n_ack;
    logic [7:0]  n_addr, n_wdata;
    logic [7:0]  n_rdata = 8'h5A;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gpmc_async_bridge dut (
        .clk(clk), .rst(rst), .gpmc_ad_in(ad_in), .gpmc_ad_out(ad_out),
        .gpmc_ad_oe(ad_oe), .gpmc_advn(advn), .gpmc_csn(csn),
        .gpmc_wein(wein), .gpmc_oen(oen), .gpmc_wait(gwait),
        .host_req(req), .host_we(we), .host_addr(addr),
        .host_wdata(wdata), .host_ack(ack), .host_rdata(rdata)
    );

    // narrow instance acknowledges its own requests immediately
    assign n_ack = n_req;

    gpmc_async_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut_n (
        .clk(clk), .rst(rst), .gpmc_ad_in(ad_in), .gpmc_ad_out(n_ad_out),
        .gpmc_ad_oe(n_ad_oe), .gpmc_advn(advn), .gpmc_csn(csn),
        .gpmc_wein(wein), .gpmc_oen(oen), .gpmc_wait(n_wait),
        .host_req(n_req), .host_we(n_we), .host_addr(n_addr),
        .host_wdata(n_wdata), .host_ack(n_ack), .host_rdata(n_rdata)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic bus_idle();
        csn = 1'b1; advn = 1'b1; wein = 1'b1; oen = 1'b1;
        step(5);
    endtask

    task automatic addr_phase(input logic [15:0] a);
        csn = 1'b0; ad_in = a; advn = 1'b0;
        step(4);
        advn = 1'b1;
        step(4);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        csn = 1'b0; advn = 1'b1; oen = 1'b0; wein = 1'b1;
        rst = 1'b1;
        step(3);
        tests++;
        if (ad_oe !== 1'b0) begin fails++; $display("FAIL reset_oe got=%b exp=0", ad_oe); end
        tests++;
        if ({req, we, gwait} !== 3'b000) begin fails++; $display("FAIL reset_ctl got=%b exp=000", {req, we, gwait}); end
        tests++;
        if ({addr, wdata, ad_out} !== 48'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", {addr, wdata, ad_out}); end
        csn = 1'b1; oen = 1'b1;
        rst = 1'b0;
        step(3);
    endtask

    task automatic test_single_write();
        bit ok;
        do_reset();
        addr_phase(16'h1234);
        tests++;
        if (addr !== 16'h1234) begin fails++; $display("FAIL wr_addr_latch got=%h exp=1234", addr); end
        ad_in = 16'hBEEF; wein = 1'b0;
        step(2);
        tests++;
        if (req !== 1'b0) begin fails++; $display("FAIL wr_latency_early got=%b exp=0", req); end
        step(1);
        tests++;
        if (req !== 1'b1) begin fails++; $display("FAIL wr_latency got=%b exp=1", req); end
        step(2);
        ack = 1'b1;
        tests++;
        if ({req, we, addr, wdata} !== {2'b11, 16'h1234, 16'hBEEF}) begin
            fails++; $display("FAIL wr_req got=%b%b %h %h exp=11 1234 beef", req, we, addr, wdata);
        end
        step(1);
        ack = 1'b0;
        tests++;
        if (req !== 1'b0) begin fails++; $display("FAIL wr_req_drop got=%b exp=0", req); end
        wein = 1'b1;
        step(6);
        tests++;
        if ({req, addr} !== {1'b0, 16'h1235}) begin fails++; $display("FAIL wr_addr_inc got=%b %h exp=0 1235", req, addr); end
        bus_idle();
        ok = 1'b1;
    endtask

    task automatic test_single_read();
        bit ok;
        do_reset();
        addr_phase(16'h0040);
        oen = 1'b0;
        #1;
        tests++;
        if (ad_oe !== 1'b1) begin fails++; $display("FAIL rd_oe_on got=%b exp=1", ad_oe); end
        rdata = 16'hA5A5;
        wait_req(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rd_req_timeout got=0 exp=1"); end
        tests++;
        if ({we, addr} !== {1'b0, 16'h0040}) begin fails++; $display("FAIL rd_req got=%b %h exp=0 0040", we, addr); end
        ack = 1'b1;
        tests++;
        if (ad_out !== 16'h0000) begin fails++; $display("FAIL rd_out_early got=%h exp=0000", ad_out); end
        step(1);
        ack = 1'b0; rdata = 16'h0;
        tests++;
        if ({req, ad_out} !== {1'b0, 16'hA5A5}) begin fails++; $display("FAIL rd_out got=%b %h exp=0 a5a5", req, ad_out); end
        oen = 1'b1;
        #1;
        tests++;
        if (ad_oe !== 1'b0) begin fails++; $display("FAIL rd_oe_off got=%b exp=0", ad_oe); end
        bus_idle();
        tests++;
        if (ad_out !== 16'hA5A5) begin fails++; $display("FAIL rd_out_hold got=%h exp=a5a5", ad_out); end
    endtask

    task automatic test_burst_read();
        bit ok;
        int acks;
        logic [15:0] exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        acks = 0;
        do_reset();
        addr_phase(16'hFFFE);
        for (int i = 0; i < 4; i++) begin
            oen = 1'b0;
            rdata = 16'h1000 + 16'(i);
            wait_req(ok);
            tests++;
            if (!ok || addr !== exp_a[i] || we !== 1'b0) begin
                fails++; $display("FAIL burst_addr%0d got=%b %h exp=1 %h", i, ok, addr, exp_a[i]);
            end
            if (ok) begin
                ack = 1'b1;
                step(1);
                ack = 1'b0;
                acks++;
            end
            tests++;
            if (ad_out !== 16'h1000 + 16'(i)) begin fails++; $display("FAIL burst_data%0d got=%h exp=%h", i, ad_out, 16'h1000 + 16'(i)); end
            oen = 1'b1;
            step(6);
        end
        tests++;
        if (acks != 4 || req !== 1'b0) begin fails++; $display("FAIL burst_acks got=%0d/%b exp=4/0", acks, req); end
        bus_idle();
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        do_reset();
        addr_phase(16'h0777);
        ad_in = 16'h5555; wein = 1'b0;
        wait_req(ok);
        rst = 1'b1;
        step(1);
        tests++;
        if ({req, addr, wdata} !== 33'h0) begin fails++; $display("FAIL rstmid got=%b %h %h exp=0 0000 0000", req, addr, wdata); end
        rst = 1'b0;
        step(6);
        tests++;
        if (req !== 1'b0) begin fails++; $display("FAIL rstmid_idle got=%b exp=0", req); end
        bus_idle();
        addr_phase(16'h0022);
        ad_in = 16'h1111; wein = 1'b0;
        wait_req(ok);
        tests++;
        if (!ok || {we, addr, wdata} !== {1'b1, 16'h0022, 16'h1111}) begin
            fails++; $display("FAIL rstmid_next got=%b %b %h %h exp=1 1 0022 1111", ok, we, addr, wdata);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        wein = 1'b1;
        bus_idle();
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        bad = 0;
        do_reset();
        addr_phase(16'h0100);
        ad_in = 16'h0F0F; wein = 1'b0;
        wait_req(ok);
        for (int i = 0; i < 20; i++) begin
`ifdef GPMC_WAIT_EN
            if (gwait !== 1'b1 || req !== 1'b1) bad++;
`else
            if (gwait !== 1'b0 || req !== 1'b1) bad++;
`endif
            step(1);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        tests++;
        if (!ok || bad != 0) begin fails++; $display("FAIL stall_hold got=%b/%0d exp=1/0", ok, bad); end
        tests++;
`ifdef GPMC_WAIT_EN
        if ({req, gwait} !== 2'b01) begin fails++; $display("FAIL stall_wait_ack1 got=%b exp=01", {req, gwait}); end
`else
        if ({req, gwait} !== 2'b00) begin fails++; $display("FAIL stall_wait_ack1 got=%b exp=00", {req, gwait}); end
`endif
        step(1);
        tests++;
        if (gwait !== 1'b0) begin fails++; $display("FAIL stall_wait_end got=%b exp=0", gwait); end
        wein = 1'b1;
        bus_idle();
    endtask

    task automatic test_protocol_error();
        do_reset();
        addr_phase(16'h0200);
        wein = 1'b0; oen = 1'b0;
        step(10);
        tests++;
        if (req !== 1'b0) begin fails++; $display("FAIL proto_err got=%b exp=0", req); end
        wein = 1'b1; oen = 1'b1;
        bus_idle();
    endtask

    task automatic test_narrow();
        bit ok;
        do_reset();
        tests++;
        if (n_ad_out !== 16'h0000) begin fails++; $display("FAIL narrow_rst got=%h exp=0000", n_ad_out); end
        addr_phase(16'h0012);
        oen = 1'b0;
        rdata = 16'hFFFF;
        wait_req(ok);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(1);
        tests++;
        if (n_ad_out !== 16'h005A) begin fails++; $display("FAIL narrow_rd got=%h exp=005a", n_ad_out); end
        oen = 1'b1;
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_read();
        test_reset_mid_write();
        test_stall();
        test_protocol_error();
        test_narrow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpmc_async_bridge.md
Name: gpmc_async_bridge

Overview:
Parametrised GPMC-to-host bridge for the BeagleWire FPGA fabric. It oversamples the GPMC bus (multiplexed address/data, asynchronous single or burst accesses) entirely in the system clock domain. It converts each access into a valid/ack request on the host side, so slow peripherals can stall a transfer. It sits between the top-level pad tri-states and the register/memory decoders.

Parameters:
ADDR_WIDTH, 16, host address width in bits; 1..16, taken from gpmc_ad_in[ADDR_WIDTH-1:0].
DATA_WIDTH, 16, host data width in bits; 1..16, uses low bits of the AD bus, upper output bits driven 0.
SYNC_STAGES, 2, synchroniser depth for all GPMC inputs; minimum 2.

Ports:
clk  input  1  system clock; sole clock of the block
rst  input  1  synchronous reset, active-high
gpmc_ad_in  input  16  AD bus value from pad buffers
gpmc_ad_out  output  16  read data to pad buffers
gpmc_ad_oe  output  1  pad output enable, 1 = FPGA drives AD bus
gpmc_advn  input  1  address valid, active-low
gpmc_csn  input  1  chip select, active-low
gpmc_wein  input  1  write enable, active-low
gpmc_oen  input  1  output enable, active-low
gpmc_wait  output  1  wait request to the host CPU, active-high (see Optional Feature)
host_req  output  1  request valid
host_we  output  1  1 = write, 0 = read; valid while host_req
host_addr  output  ADDR_WIDTH  request address
host_wdata  output  DATA_WIDTH  write data
host_ack  input  1  request accepted/completed this cycle
host_rdata  input  DATA_WIDTH  read data; sampled in the host_ack cycle

Behaviour:
- Synchroniser: SYNC_STAGES flops on csn/advn/wein/oen and ad_in. Control flops reset to 1; data flops reset to 0. Edge detect uses one extra flop: a falling edge is prev=1, now=0.
- Reset values: host_req=0, host_we=0, host_addr=0, host_wdata=0, gpmc_ad_out=0, gpmc_wait=0, state=IDLE.
- gpmc_ad_oe is combinational from raw pins: !csn & advn & !oen & wein & !rst. No register latency, so bus turnaround follows the CPU.
- FSM states: IDLE, ADDR, WR_REQ, RD_REQ, HOLD.
- IDLE: csn_s=0 & advn_s=0 -> latch host_addr <= ad_s[ADDR_WIDTH-1:0], go to ADDR.
- ADDR: advn_s=0 keeps relatching the address. Once advn_s=1: wein falling edge -> host_wdata <= ad_s[DATA_WIDTH-1:0], go to WR_REQ. oen falling edge -> go to RD_REQ. csn_s=1 -> IDLE.
- ADDR, both edges in the same cycle: protocol error; ignored, stay in ADDR.
- WR_REQ/RD_REQ: host_req=1, host_we=1/0. req, we, addr and wdata stay stable until host_ack.
  - On host_ack: deassert req the next cycle, go to HOLD.
  - In RD_REQ: also load gpmc_ad_out <= zero-extended host_rdata.
  - csn deasserting while a request is pending does not cancel it; the request completes, then the FSM returns to IDLE.
- HOLD: wait until the active strobe (wein or oen) is high in the synchronised domain.
  - Then host_addr <= host_addr+1 (burst auto-increment, wraps 2^ADDR_WIDTH-1 -> 0) and go to ADDR.
  - csn_s=1 at any point in HOLD -> IDLE.
- Latency: raw strobe fall -> host_req high = SYNC_STAGES+1 cycles. host_ack in cycle N -> gpmc_ad_out valid in cycle N+1.
- gpmc_ad_out holds its value until the next read ack or reset.
- Reset asserted mid-access: everything returns to reset values next edge; no request completes. The host sees host_req drop without ack.
- host_ack while host_req=0 is ignored.

Optional Feature:
GPMC_WAIT_EN.
- Defined: gpmc_wait=1 from the cycle a wein/oen falling edge is detected until the cycle after host_ack; 0 otherwise and in reset. The CPU must have wait monitoring enabled.
- Undefined: gpmc_wait tied 0. GPMC timing must guarantee the strobe stays low for at least SYNC_STAGES+3+max host latency clk cycles; a host stall beyond this corrupts reads. No other behaviour changes.

Test Plan:
- Single write: csn=0, advn pulse with AD=0x1234, wein low with AD=0xBEEF, ack 2 cycles after req -> one request addr=0x1234, we=1, wdata=0xBEEF; req high exactly until ack.
- Single read: addr 0x0040, oen low, host_rdata=0xA5A5 at ack -> gpmc_ad_out=0xA5A5 the cycle after ack; gpmc_ad_oe high only while !csn & advn & !oen & wein.
- Burst read of 4 at addr 0xFFFE, ADDR_WIDTH=16 -> requests at 0xFFFE, 0xFFFF, 0x0000, 0x0001; exactly 4 acks consumed.
- Reset mid-write: rst=1 while host_req=1 -> next cycle req=0, addr=0, FSM IDLE; next access works normally.
- Stall with GPMC_WAIT_EN: host_ack delayed 20 cycles -> gpmc_wait high from edge detect to ack+1; without the macro, gpmc_wait stays 0.
- Protocol error and narrow widths: wein and oen fall together -> no request. DATA_WIDTH=8 read 0x5A -> gpmc_ad_out=0x005A.
